// File: rtl/xm23_pkg.sv
// Shared definitions for the XM23 execute/writeback datapath.
package xm23_pkg;

    // ALU operation class as seen by the flag logic; encoding 3'd7 is unused
    // and is treated like CLS_NONE by consumers.
    typedef enum logic [2:0] {
        CLS_ADD   = 3'd0,
        CLS_ADDC  = 3'd1,
        CLS_SUB   = 3'd2,
        CLS_SUBC  = 3'd3,
        CLS_DADD  = 3'd4,
        CLS_LOGIC = 3'd5,
        CLS_NONE  = 3'd6
    } alu_class_t;

    // PSW bit positions within the {V,N,Z,C} vector.
    localparam int unsigned PSW_C = 0;
    localparam int unsigned PSW_Z = 1;
    localparam int unsigned PSW_N = 2;
    localparam int unsigned PSW_V = 3;

endpackage

// File: rtl/psw_wb_stage_bcd_carry.sv
// Decimal carry-out of a packed-BCD addition, byte (2 digits) or word width.
module bcd_carry #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         byte_mode,
    output logic         carry
);

    localparam int unsigned NIB = W / 4;

    logic [NIB:0] c;
    logic [4:0]   digit_sum;

    // Ripple a decimal carry through each digit: a digit sum above 9 carries.
    always_comb begin
        c         = '0;
        c[0]      = cin;
        digit_sum = '0;
        for (int unsigned i = 0; i < NIB; i++) begin
            digit_sum = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c[i]};
            c[i+1]    = (digit_sum > 5'd9);
        end
    end

    assign carry = byte_mode ? c[2] : c[NIB];

endmodule

// File: rtl/psw_wb_stage.sv
// Writeback stage: registers the ALU result for register writeback and
// maintains the processor status word {V,N,Z,C}.
module psw_wb_stage
    import xm23_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] alu_result,
    input  logic         enable_psw_msk,
    input  logic [2:0]   op_class,
    input  logic         byte_mode,
    input  logic [2:0]   dst,
    input  logic         wb_en,
    input  logic         in_valid,
    input  logic         stall,
    input  logic         flush,
    input  logic [3:0]   setcc,
    input  logic [3:0]   clrcc,
    output logic         carry_out,
    output logic [3:0]   psw,
    output logic         wb_valid,
    output logic         wb_we,
    output logic         wb_byte,
    output logic [2:0]   wb_dst,
    output logic [W-1:0] wb_data
);

    alu_class_t   cls;
    logic         cap;
    logic [W-1:0] mask;
    logic [W-1:0] b_eff;
    logic         cin;
    logic [W:0]   sum;
    logic         bin_carry;
    logic         dec_carry;
    logic         sign_a;
    logic         sign_b;
    logic         sign_r;
    logic         z_flag;
    logic [3:0]   alu_psw;
    logic [3:0]   psw_next;

    assign cls       = alu_class_t'(op_class);
    assign cap       = in_valid & ~stall & ~flush;
    assign carry_out = psw[PSW_C];

    // Operand conditioning and binary carry out of the active msb.
    always_comb begin
        mask      = byte_mode ? {{(W-8){1'b0}}, 8'hFF} : '1;
        b_eff     = (cls == CLS_SUB || cls == CLS_SUBC) ? ~b : b;
        case (cls)
            CLS_ADD: cin = 1'b0;
            CLS_SUB: cin = 1'b1;
            default: cin = psw[PSW_C];
        endcase
        sum       = {1'b0, a & mask} + {1'b0, b_eff & mask} + {{W{1'b0}}, cin};
        bin_carry = byte_mode ? sum[8] : sum[W];
        sign_a    = byte_mode ? a[7] : a[W-1];
        sign_b    = byte_mode ? b_eff[7] : b_eff[W-1];
        sign_r    = byte_mode ? alu_result[7] : alu_result[W-1];
        z_flag    = ((alu_result & mask) == '0);
    end

    bcd_carry #(.W(W)) u_bcd_carry (
        .a         (a),
        .b         (b),
        .cin       (psw[PSW_C]),
        .byte_mode (byte_mode),
        .carry     (dec_carry)
    );

    // ALU flag update for captured instructions, then explicit clear/set masks.
    always_comb begin
        alu_psw = psw;
        if (cap && enable_psw_msk) begin
            case (cls)
                CLS_ADD, CLS_ADDC, CLS_SUB, CLS_SUBC: begin
                    alu_psw[PSW_Z] = z_flag;
                    alu_psw[PSW_N] = sign_r;
                    alu_psw[PSW_C] = bin_carry;
                    alu_psw[PSW_V] = (sign_a == sign_b) && (sign_r != sign_a);
                end
                CLS_DADD: begin
                    alu_psw[PSW_Z] = z_flag;
                    alu_psw[PSW_N] = sign_r;
                    alu_psw[PSW_C] = dec_carry;
                end
                CLS_LOGIC: begin
                    alu_psw[PSW_Z] = z_flag;
                    alu_psw[PSW_N] = sign_r;
                end
                default: ;
            endcase
        end
        psw_next = (alu_psw & ~clrcc) | setcc;
    end

    // Stage registers: flush kills, stall holds, otherwise capture or bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psw      <= '0;
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_byte  <= 1'b0;
            wb_dst   <= '0;
            wb_data  <= '0;
        end else begin
            psw <= psw_next;
            if (flush) begin
                wb_valid <= 1'b0;
                wb_we    <= 1'b0;
            end else if (!stall) begin
                if (in_valid) begin
                    wb_valid <= 1'b1;
                    wb_we    <= wb_en;
                    wb_data  <= alu_result;
                    wb_dst   <= dst;
                    wb_byte  <= byte_mode;
                end else begin
                    wb_valid <= 1'b0;
                    wb_we    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_psw_wb_stage.sv
// Self-checking bench for psw_wb_stage using a reference model and a
// scoreboard queue of expected stage outputs.
module tb_psw_wb_stage;
    import xm23_pkg::*;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic        byt;
        logic [2:0]  dst;
        logic [15:0] data;
        logic [3:0]  psw;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = '0, b = '0, alu_result = '0;
    logic        enable_psw_msk = 1'b0;
    logic [2:0]  op_class = 3'd6;
    logic        byte_mode = 1'b0;
    logic [2:0]  dst = '0;
    logic        wb_en = 1'b0, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [3:0]  setcc = '0, clrcc = '0;
    logic        carry_out;
    logic [3:0]  psw;
    logic        wb_valid, wb_we, wb_byte;
    logic [2:0]  wb_dst;
    logic [15:0] wb_data;

    out_t obs, m, e;
    out_t expq[$];
    int   tests = 0;
    int   fails = 0;

    assign obs = {wb_valid, wb_we, wb_byte, wb_dst, wb_data, psw};

    psw_wb_stage #(.W(16)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .alu_result(alu_result),
        .enable_psw_msk(enable_psw_msk), .op_class(op_class), .byte_mode(byte_mode),
        .dst(dst), .wb_en(wb_en), .in_valid(in_valid), .stall(stall), .flush(flush),
        .setcc(setcc), .clrcc(clrcc), .carry_out(carry_out), .psw(psw),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_byte(wb_byte), .wb_dst(wb_dst),
        .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    function automatic int bcd_val(input logic [15:0] v, input logic bm);
        int r = 0;
        for (int i = (bm ? 1 : 3); i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] rand_bcd();
        logic [15:0] v;
        for (int i = 0; i < 4; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model, push its expectation,
    // and return #1 after the capturing edge.
    task automatic step(input logic [15:0] ia, ib, ir, input logic ien,
                        input logic [2:0] ic, input logic ibm, input logic [2:0] idst,
                        input logic iwe, iiv, ist, ifl, input logic [3:0] iset, iclr);
        logic        cap, cin;
        logic [3:0]  np;
        logic [15:0] bb, msk;
        logic [16:0] full;
        int          msb;
        a = ia; b = ib; alu_result = ir; enable_psw_msk = ien; op_class = ic;
        byte_mode = ibm; dst = idst; wb_en = iwe; in_valid = iiv; stall = ist;
        flush = ifl; setcc = iset; clrcc = iclr;
        cap = iiv && !ist && !ifl;
        np  = m.psw;
        msk = ibm ? 16'h00FF : 16'hFFFF;
        msb = ibm ? 7 : 15;
        if (cap && ien && ic < 3'd6) begin
            np[1] = ((ir & msk) == 16'h0);
            np[2] = ir[msb];
            cin   = (ic == 3'd0) ? 1'b0 : (ic == 3'd2) ? 1'b1 : m.psw[0];
            if (ic <= 3'd3) begin
                bb    = (ic >= 3'd2) ? ~ib : ib;
                full  = {1'b0, ia & msk} + {1'b0, bb & msk} + {16'h0, cin};
                np[0] = ibm ? full[8] : full[16];
                np[3] = (ia[msb] == bb[msb]) && (ir[msb] != ia[msb]);
            end else if (ic == 3'd4) begin
                np[0] = (bcd_val(ia, ibm) + bcd_val(ib, ibm) + int'(cin)) > (ibm ? 99 : 9999);
            end
        end
        m.psw = (np & ~iclr) | iset;
        if (ifl) begin
            m.valid = 1'b0; m.we = 1'b0;
        end else if (!ist) begin
            if (iiv) begin
                m.valid = 1'b1; m.we = iwe; m.data = ir; m.dst = idst; m.byt = ibm;
            end else begin
                m.valid = 1'b0; m.we = 1'b0;
            end
        end
        expq.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] iset, iclr);
        step(16'h0, 16'h0, 16'h0, 1'b0, 3'd6, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, iset, iclr);
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if (obs !== '0 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: got %h carry %b, expected 0 carry 0", obs, carry_out);
        end
        @(negedge clk);
        rst = 1'b0;
        m = '0;
        @(posedge clk);
        #1;
        idle(4'h0, 4'h0);
        e = expq.pop_front();
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL reset_idle: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_add_overflow();
        step(16'h7FFF, 16'h0001, 16'h8000, 1'b1, CLS_ADD, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        e = expq.pop_front();
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL add_overflow_model: got %h expected %h", obs, e);
        end
        tests++;
        if (psw !== 4'b1100 || wb_data !== 16'h8000 || wb_valid !== 1'b1) begin
            fails++;
            $display("FAIL add_overflow_const: got psw %b data %h valid %b, expected 1100 8000 1",
                     psw, wb_data, wb_valid);
        end
    endtask

    task automatic test_sub_zero();
        step(16'h0005, 16'h0005, 16'h0000, 1'b1, CLS_SUB, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        e = expq.pop_front();
        tests++;
        if (obs !== e || psw !== 4'b0011) begin
            fails++;
            $display("FAIL sub_zero: got %h expected %h (psw 0011)", obs, e);
        end
    endtask

    task automatic test_byte_add();
        step(16'h00FF, 16'h0001, 16'h0100, 1'b1, CLS_ADD, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        e = expq.pop_front();
        tests++;
        if (obs !== e || psw !== 4'b0011 || wb_byte !== 1'b1) begin
            fails++;
            $display("FAIL byte_add: got %h expected %h (psw 0011 byte 1)", obs, e);
        end
    endtask

    task automatic test_logic_addc();
        idle(4'b0001, 4'b1111);
        e = expq.pop_front();
        tests++;
        if (obs !== e || psw !== 4'b0001) begin
            fails++;
            $display("FAIL set_carry: got %h expected %h (psw 0001)", obs, e);
        end
        step(16'h00F0, 16'h000F, 16'h0000, 1'b1, CLS_LOGIC, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        e = expq.pop_front();
        tests++;
        if (obs !== e || psw !== 4'b0011) begin
            fails++;
            $display("FAIL logic_keeps_c: got %h expected %h (psw 0011)", obs, e);
        end
        tests++;
        if (carry_out !== 1'b1) begin
            fails++;
            $display("FAIL addc_carry_in: got %b expected 1", carry_out);
        end
        step(16'h0001, 16'h0001, 16'h0003, 1'b1, CLS_ADDC, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        e = expq.pop_front();
        tests++;
        if (obs !== e || wb_data !== 16'h0003 || psw !== 4'b0000) begin
            fails++;
            $display("FAIL addc_result: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_stall_flush();
        step(16'h0001, 16'h0001, 16'h0002, 1'b1, CLS_ADD, 1'b0, 3'd6, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        e = expq.pop_front();
        tests++;
        if (obs !== e) begin
            fails++;
            $display("FAIL pre_stall: got %h expected %h", obs, e);
        end
        for (int i = 0; i < 3; i++) begin
            step(16'h8000, 16'h8000, 16'h0000, 1'b1, CLS_ADD, 1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0);
            e = expq.pop_front();
            tests++;
            if (obs !== e) begin
                fails++;
                $display("FAIL stall_hold: cycle %0d got %h expected %h", i, obs, e);
            end
        end
        step(16'h8000, 16'h8000, 16'h0000, 1'b1, CLS_ADD, 1'b0, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0);
        e = expq.pop_front();
        tests++;
        if (obs !== e || wb_valid !== 1'b0 || wb_we !== 1'b0) begin
            fails++;
            $display("FAIL flush_kill: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_dadd_and_reset();
        idle(4'h0, 4'hF);
        void'(expq.pop_front());
        step(16'h9999, 16'h0001, 16'h0000, 1'b1, CLS_DADD, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        e = expq.pop_front();
        tests++;
        if (obs !== e || psw[0] !== 1'b1) begin
            fails++;
            $display("FAIL dadd_carry: got %h expected %h (C=1)", obs, e);
        end
        a = 16'h1234; b = 16'h1111; alu_result = 16'h2345; enable_psw_msk = 1'b1;
        op_class = CLS_ADD; in_valid = 1'b1; wb_en = 1'b1; dst = 3'd2;
        #2 rst = 1'b1;
        #1;
        tests++;
        if (obs !== '0 || carry_out !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got %h carry %b, expected 0 carry 0", obs, carry_out);
        end
        in_valid = 1'b0; enable_psw_msk = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m = '0;
        expq.delete();
        @(posedge clk);
        #1;
        step(16'h0002, 16'h0003, 16'h0005, 1'b1, CLS_ADD, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
        e = expq.pop_front();
        tests++;
        if (obs !== e || wb_data !== 16'h0005 || wb_valid !== 1'b1) begin
            fails++;
            $display("FAIL post_reset_cap: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_setclr();
        idle(4'b0101, 4'b0111);
        e = expq.pop_front();
        tests++;
        if (obs !== e || psw[0] !== 1'b1 || psw[2] !== 1'b1 || psw[1] !== 1'b0) begin
            fails++;
            $display("FAIL set_wins: got %h expected %h", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ra, rb, rr;
        logic [2:0]  rc;
        for (int i = 0; i < 60; i++) begin
            rc = 3'($urandom_range(0, 6));
            ra = (rc == CLS_DADD) ? rand_bcd() : 16'($urandom);
            rb = (rc == CLS_DADD) ? rand_bcd() : 16'($urandom);
            rr = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            step(ra, rb, rr, 1'($urandom), rc, 1'($urandom), 3'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0,
                 ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0);
            e = expq.pop_front();
            tests++;
            if (obs !== e || carry_out !== e.psw[0]) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got %h carry %b expected %h", i, obs, carry_out, e);
            end
        end
    endtask

    initial begin
        m = '0;
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_byte_add();
        test_logic_addc();
        test_stall_flush();
        test_dadd_and_reset();
        test_setclr();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
